// File: rtl/cfg_loader_ctrl.sv
// Power-up config sequencer: settle, read EEPROM config page, validate, retry, publish node ID/trigger enable.
// Result registers update one cycle after the page is captured; waits for i_eep_busy low before each start.
module cfg_loader_ctrl #(
    parameter logic [31:0] INIT_WAIT_CYCLES = 32'd10000000,
    parameter logic [31:0] TIMEOUT_CYCLES   = 32'd2000000,
    parameter int unsigned MAX_RETRIES      = 3,
    parameter logic [7:0]  CFG_PAGE         = 8'h00,
    parameter logic [7:0]  CFG_MAGIC        = 8'hA5,
    parameter logic [7:0]  RX_ID_1          = 8'd2,
    parameter logic [7:0]  RX_ID_2          = 8'd3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_reload,
    output logic        o_eep_start,
    output logic [7:0]  o_eep_page_addr,
    input  logic        i_eep_busy,
    input  logic        i_eep_done,
    input  logic [63:0] i_page_data,
    output logic [7:0]  o_node_id,
    output logic [7:0]  o_role_flags,
    output logic        o_trigger_enable,
    output logic        o_cfg_valid,
    output logic        o_cfg_error,
    output logic        o_loading
);

    typedef enum logic [2:0] {
        S_INIT_WAIT,
        S_ISSUE,
        S_WAIT_DONE,
        S_CHECK,
        S_RUN,
        S_FAIL
    } state_t;

    localparam logic [3:0] MAX_RETRY_CNT = MAX_RETRIES[3:0];

    state_t      state_q, state_d;
    logic [31:0] wait_q, wait_d;
    logic [31:0] tmo_q, tmo_d;
    logic [3:0]  retry_q, retry_d;
    logic [63:0] page_q, page_d;
    logic [7:0]  node_q, node_d;
    logic [7:0]  role_q, role_d;
    logic        trig_q, trig_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;
    logic        loading_q, loading_d;
    logic        start;
    logic        attempt_fail;
    logic        page_ok;

    assign page_ok = (page_q[23:16] == CFG_MAGIC) &&
                     (page_q[63:56] == (page_q[7:0] ^ page_q[15:8] ^ page_q[23:16] ^ page_q[31:24] ^
                                        page_q[39:32] ^ page_q[47:40] ^ page_q[55:48]));

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        tmo_d        = tmo_q;
        retry_d      = retry_q;
        page_d       = page_q;
        node_d       = node_q;
        role_d       = role_q;
        trig_d       = trig_q;
        valid_d      = valid_q;
        error_d      = error_q;
        start        = 1'b0;
        attempt_fail = 1'b0;

        case (state_q)
            S_INIT_WAIT: begin
                retry_d = 4'd0;
                if (wait_q >= INIT_WAIT_CYCLES - 32'd1) begin
                    state_d = S_ISSUE;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            S_ISSUE: begin
                if (!i_eep_busy) begin
                    start   = 1'b1;
                    tmo_d   = 32'd0;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // A completion in the final timeout cycle still counts as a successful read.
                if (i_eep_done) begin
                    page_d  = i_page_data;
                    state_d = S_CHECK;
                end else if (tmo_q >= TIMEOUT_CYCLES - 32'd1) begin
                    attempt_fail = 1'b1;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            S_CHECK: begin
                if (page_ok) begin
                    node_d  = page_q[7:0];
                    role_d  = page_q[15:8];
                    trig_d  = (page_q[7:0] == RX_ID_1) || (page_q[7:0] == RX_ID_2);
                    valid_d = 1'b1;
                    error_d = 1'b0;
                    state_d = S_RUN;
                end else begin
                    attempt_fail = 1'b1;
                end
            end
            S_RUN, S_FAIL: begin
                // Node ID and role keep their last good values until a new page passes.
                if (i_reload) begin
                    valid_d = 1'b0;
                    trig_d  = 1'b0;
                    error_d = 1'b0;
                    retry_d = 4'd0;
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_INIT_WAIT;
        endcase

        if (attempt_fail) begin
            if (retry_q < MAX_RETRY_CNT) begin
                retry_d = retry_q + 4'd1;
                state_d = S_ISSUE;
            end else begin
                error_d = 1'b1;
                state_d = S_FAIL;
            end
        end

        loading_d = (state_d == S_INIT_WAIT) || (state_d == S_ISSUE) ||
                    (state_d == S_WAIT_DONE) || (state_d == S_CHECK);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_INIT_WAIT;
            wait_q    <= 32'd0;
            tmo_q     <= 32'd0;
            retry_q   <= 4'd0;
            page_q    <= 64'd0;
            node_q    <= 8'd0;
            role_q    <= 8'd0;
            trig_q    <= 1'b0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            loading_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            tmo_q     <= tmo_d;
            retry_q   <= retry_d;
            page_q    <= page_d;
            node_q    <= node_d;
            role_q    <= role_d;
            trig_q    <= trig_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
            loading_q <= loading_d;
        end
    end

    assign o_eep_start      = start;
    assign o_eep_page_addr  = CFG_PAGE;
    assign o_node_id        = node_q;
    assign o_role_flags     = role_q;
    assign o_trigger_enable = trig_q;
    assign o_cfg_valid      = valid_q;
    assign o_cfg_error      = error_q;
    assign o_loading        = loading_q;

endmodule

// File: tb/tb_cfg_loader_ctrl.sv
// Scoreboard bench for cfg_loader_ctrl: stimulus pushes expected start pulses and status changes,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_cfg_loader_ctrl;

    localparam logic [31:0] INIT_W = 32'd16;
    localparam logic [31:0] TMO    = 32'd32;
    localparam int          K_START = 0;
    localparam int          K_STAT  = 1;

    typedef struct {
        int         kind;
        int         exp_cyc;
        int         exp_gap;
        logic       valid;
        logic       error;
        logic       trig;
        logic       loading;
        logic [7:0] node;
        logic [7:0] role;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        i_reload = 1'b0;
    logic        o_eep_start;
    logic [7:0]  o_eep_page_addr;
    logic        i_eep_busy = 1'b0;
    logic        i_eep_done = 1'b0;
    logic [63:0] i_page_data = 64'd0;
    logic [7:0]  o_node_id;
    logic [7:0]  o_role_flags;
    logic        o_trigger_enable;
    logic        o_cfg_valid;
    logic        o_cfg_error;
    logic        o_loading;

    int   cyc = 0;
    int   base = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_start = 0;
    logic prev_start = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_error = 1'b0;
    exp_t sb[$];

    cfg_loader_ctrl #(
        .INIT_WAIT_CYCLES(INIT_W),
        .TIMEOUT_CYCLES  (TMO),
        .MAX_RETRIES     (2),
        .CFG_PAGE        (8'h00),
        .CFG_MAGIC       (8'hA5),
        .RX_ID_1         (8'd2),
        .RX_ID_2         (8'd3)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_reload        (i_reload),
        .o_eep_start     (o_eep_start),
        .o_eep_page_addr (o_eep_page_addr),
        .i_eep_busy      (i_eep_busy),
        .i_eep_done      (i_eep_done),
        .i_page_data     (i_page_data),
        .o_node_id       (o_node_id),
        .o_role_flags    (o_role_flags),
        .o_trigger_enable(o_trigger_enable),
        .o_cfg_valid     (o_cfg_valid),
        .o_cfg_error     (o_cfg_error),
        .o_loading       (o_loading)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    function automatic exp_t ev_start(input int c, input int g);
        exp_t e;
        e = '{kind: K_START, exp_cyc: c, exp_gap: g, valid: 1'b0, error: 1'b0,
              trig: 1'b0, loading: 1'b0, node: 8'h00, role: 8'h00};
        return e;
    endfunction

    function automatic exp_t ev_stat(input int c, input int g, input logic v, input logic er,
                                     input logic tr, input logic ld, input logic [7:0] n,
                                     input logic [7:0] r);
        exp_t e;
        e = '{kind: K_STAT, exp_cyc: c, exp_gap: g, valid: v, error: er,
              trig: tr, loading: ld, node: n, role: r};
        return e;
    endfunction

    function automatic logic [63:0] mkpage(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b7);
        return {b7, 32'h0, b2, b1, b0};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            prev_start = 1'b0;
            prev_valid = 1'b0;
            prev_error = 1'b0;
        end else begin
            if (o_eep_start) begin
                chk("start_width", 64'(prev_start), 64'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_start", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind_start", 64'(e.kind), 64'(K_START));
                    if (e.exp_cyc >= 0) chk("start_cycle", 64'(cyc), 64'(e.exp_cyc));
                    if (e.exp_gap > 0) chk("start_gap", 64'(cyc - last_start), 64'(e.exp_gap));
                end
                last_start = cyc;
            end
            if (o_cfg_valid !== prev_valid || o_cfg_error !== prev_error) begin
                if (sb.size() == 0) begin
                    chk("unexpected_status", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind_status", 64'(e.kind), 64'(K_STAT));
                    if (e.exp_cyc >= 0) chk("status_cycle", 64'(cyc), 64'(e.exp_cyc));
                    if (e.exp_gap > 0) chk("status_gap", 64'(cyc - last_start), 64'(e.exp_gap));
                    chk("cfg_valid", 64'(o_cfg_valid), 64'(e.valid));
                    chk("cfg_error", 64'(o_cfg_error), 64'(e.error));
                    chk("trigger_enable", 64'(o_trigger_enable), 64'(e.trig));
                    chk("loading", 64'(o_loading), 64'(e.loading));
                    chk("node_id", 64'(o_node_id), 64'(e.node));
                    chk("role_flags", 64'(o_role_flags), 64'(e.role));
                end
            end
            chk("trig_without_valid", 64'(o_trigger_enable & ~o_cfg_valid), 64'd0);
            chk("valid_and_error", 64'(o_cfg_valid & o_cfg_error), 64'd0);
            prev_start = o_eep_start;
            prev_valid = o_cfg_valid;
            prev_error = o_cfg_error;
        end
    end

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_start"},   64'(o_eep_start), 64'd0);
        chk({nm, "_addr"},    64'(o_eep_page_addr), 64'h00);
        chk({nm, "_node"},    64'(o_node_id), 64'd0);
        chk({nm, "_role"},    64'(o_role_flags), 64'd0);
        chk({nm, "_trig"},    64'(o_trigger_enable), 64'd0);
        chk({nm, "_valid"},   64'(o_cfg_valid), 64'd0);
        chk({nm, "_error"},   64'(o_cfg_error), 64'd0);
        chk({nm, "_loading"}, 64'(o_loading), 64'd0);
    endtask

    task automatic do_reset(input logic busy_lvl);
        reset_n     = 1'b0;
        i_reload    = 1'b0;
        i_eep_busy  = busy_lvl;
        i_eep_done  = 1'b0;
        i_page_data = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        base    = cyc;
    endtask

    task automatic wait_start();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_eep_start) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL start_wait_timeout: got no start expected a start within 200 cycles");
        end
    endtask

    task automatic respond(input logic [63:0] page, input int dly);
        repeat (dly - 1) @(posedge clk);
        #1;
        i_eep_done  = 1'b1;
        i_page_data = page;
        @(posedge clk);
        #1;
        i_eep_done  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reload();
        i_reload = 1'b1;
        @(posedge clk);
        #1;
        i_reload = 1'b0;
    endtask

    int rc;

    initial begin
        #2;
        // 1: good page, node 02, start exactly 16 cycles after release, valid 6 cycles later
        do_reset(1'b0);
        sb.push_back(ev_start(base + 16, 0));
        sb.push_back(ev_stat(base + 22, 0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h02, 8'h00));
        wait_start();
        respond(mkpage(8'h02, 8'h00, 8'hA5, 8'hA7), 5);
        idle(5);
        chk("t1_drained", 64'(sb.size()), 64'd0);

        // 2: good page, node 07 does not enable triggers
        do_reset(1'b0);
        sb.push_back(ev_start(base + 16, 0));
        sb.push_back(ev_stat(-1, 4, 1'b1, 1'b0, 1'b0, 1'b0, 8'h07, 8'h00));
        wait_start();
        respond(mkpage(8'h07, 8'h00, 8'hA5, 8'hA2), 3);
        idle(5);
        chk("t2_drained", 64'(sb.size()), 64'd0);

        // 3: busy held through 10 cycles of ISSUE delays the single start
        do_reset(1'b1);
        sb.push_back(ev_start(base + 26, 0));
        sb.push_back(ev_stat(-1, 6, 1'b1, 1'b0, 1'b1, 1'b0, 8'h02, 8'h00));
        while (cyc < base + 26) idle(1);
        i_eep_busy = 1'b0;
        wait_start();
        respond(mkpage(8'h02, 8'h00, 8'hA5, 8'hA7), 5);
        idle(5);
        chk("t3_drained", 64'(sb.size()), 64'd0);

        // 4: done never arrives, three attempts 33 cycles apart then error
        do_reset(1'b0);
        sb.push_back(ev_start(base + 16, 0));
        sb.push_back(ev_start(-1, 33));
        sb.push_back(ev_start(-1, 33));
        sb.push_back(ev_stat(-1, 33, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00));
        wait_start();
        wait_start();
        wait_start();
        idle(40);
        chk("t4_drained", 64'(sb.size()), 64'd0);

        // 5: bad checksum then good page with node 03
        do_reset(1'b0);
        sb.push_back(ev_start(base + 16, 0));
        sb.push_back(ev_start(-1, 6));
        sb.push_back(ev_stat(-1, 6, 1'b1, 1'b0, 1'b1, 1'b0, 8'h03, 8'h00));
        wait_start();
        respond(mkpage(8'h03, 8'h00, 8'hA5, 8'h00), 5);
        wait_start();
        respond(mkpage(8'h03, 8'h00, 8'hA5, 8'hA6), 5);
        idle(5);
        chk("t5_drained", 64'(sb.size()), 64'd0);

        // 6a: reload from RUN, every attempt has a wrong magic byte
        rc = cyc;
        sb.push_back(ev_start(rc + 1, 0));
        sb.push_back(ev_stat(rc + 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 8'h00));
        sb.push_back(ev_start(-1, 6));
        sb.push_back(ev_start(-1, 6));
        sb.push_back(ev_stat(-1, 6, 1'b0, 1'b1, 1'b0, 1'b0, 8'h03, 8'h00));
        pulse_reload();
        for (int a = 0; a < 3; a++) begin
            wait_start();
            respond(mkpage(8'h05, 8'h00, 8'h00, 8'h05), 5);
        end
        idle(5);
        chk("t6a_drained", 64'(sb.size()), 64'd0);

        // 6b: reload from FAIL with a good page carrying a role byte
        rc = cyc;
        sb.push_back(ev_start(rc + 1, 0));
        sb.push_back(ev_stat(rc + 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 8'h00));
        sb.push_back(ev_stat(-1, 6, 1'b1, 1'b0, 1'b1, 1'b0, 8'h02, 8'h3C));
        pulse_reload();
        wait_start();
        respond(mkpage(8'h02, 8'h3C, 8'hA5, 8'h9B), 5);
        idle(5);
        chk("t6b_drained", 64'(sb.size()), 64'd0);

        // 6c: reset asserted between clock edges while waiting for done
        rc = cyc;
        sb.push_back(ev_start(rc + 1, 0));
        sb.push_back(ev_stat(rc + 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h02, 8'h3C));
        pulse_reload();
        wait_start();
        idle(2);
        #2;
        reset_n = 1'b0;
        #1;
        chk_outputs_zero("async_reset");
        chk("t6c_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
